// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential single-precision divider.
// Holds the operand class codes, FSM state encoding, the canonical NaN
// result, the exponent bias, the division iteration count and a small
// classification helper.
package fp_div_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'b000,
    CLS_SUB  = 3'b001,
    CLS_NORM = 3'b011,
    CLS_INF  = 3'b100,
    CLS_NAN  = 3'b110
  } fp_class_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    DIV  = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [31:0]        NAN_RES = 32'hFFFF_FFFF;
  localparam logic signed [9:0]  BIAS    = 10'sd127;
  localparam int unsigned        ITERS   = 25;

  // Classify an operand from its exponent and mantissa fields (sign excluded).
  function automatic fp_class_e classify(input logic [30:0] x);
    if (x[30:23] == 8'h00) begin
      return (x[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
    end else if (x[30:23] == 8'hFF) begin
      return (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/zero_counter.sv
// Leading-zero counter for a 24-bit significand.
// Ports:
//   value - 24-bit input vector
//   count - number of leading zeros (24 when value is all zero)
module zero_counter (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    count = 5'd24;
    // Ascending scan: the highest set bit is the last one to overwrite count.
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/floating_div_seq.sv
// Sequential IEEE-754 single-precision divider (truncating, flush-to-zero).
// One restoring-division quotient bit is produced per cycle.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_a/i_b  - dividend / divisor, sampled when i_valid && o_ready
//   i_valid  - operands valid
//   o_ready  - high only while idle
//   o_res    - quotient a/b, held stable while o_valid is high
//   o_valid  - result valid, held until i_ready
//   i_ready  - downstream consumes o_res
module floating_div_seq
  import fp_div_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_res,
  output logic        o_valid,
  input  logic        i_ready
);

  state_e             state;
  logic [31:0]        a_q, b_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mb_q;
  logic [24:0]        rem_q, quo_q;
  logic [4:0]         cnt;

  // Operand preparation (consumed in PREP).
  fp_class_e          cls_a, cls_b;
  logic [23:0]        sig_a, sig_b, norm_a, norm_b;
  logic [4:0]         lz_a, lz_b;
  logic signed [9:0]  ea, eb;
  logic               special;
  logic [31:0]        special_res;

  // Subnormal significands carry a 0 hidden bit.
  assign sig_a = {1'b0, a_q[22:0]};
  assign sig_b = {1'b0, b_q[22:0]};

  zero_counter u_lz_a (.value(sig_a), .count(lz_a));
  zero_counter u_lz_b (.value(sig_b), .count(lz_b));

  always_comb begin
    cls_a = classify(a_q[30:0]);
    cls_b = classify(b_q[30:0]);

    if (cls_a == CLS_SUB) begin
      norm_a = sig_a << lz_a;
      ea     = 10'sd1 - $signed({5'd0, lz_a});
    end else begin
      norm_a = {1'b1, a_q[22:0]};
      ea     = $signed({2'b00, a_q[30:23]});
    end

    if (cls_b == CLS_SUB) begin
      norm_b = sig_b << lz_b;
      eb     = 10'sd1 - $signed({5'd0, lz_b});
    end else begin
      norm_b = {1'b1, b_q[22:0]};
      eb     = $signed({2'b00, b_q[30:23]});
    end

    // Special cases in priority order; NaN result ignores the sign.
    special     = 1'b1;
    special_res = NAN_RES;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
        (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
      special_res = NAN_RES;
    end else if (cls_a == CLS_INF || cls_b == CLS_ZERO) begin
      special_res = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
    end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
      special_res = {a_q[31] ^ b_q[31], 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring-division step: subtract when the partial remainder allows.
  logic        quo_bit;
  logic [24:0] rem_sub, rem_next;

  always_comb begin
    quo_bit  = (rem_q >= {1'b0, mb_q});
    rem_sub  = quo_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_next = rem_sub << 1;
  end

  // Normalize the quotient, then saturate to inf or flush to zero.
  logic signed [9:0] exp_adj;
  logic [22:0]       mant;
  logic [31:0]       packed_res;

  always_comb begin
    exp_adj = quo_q[24] ? exp_q : (exp_q - 10'sd1);
    mant    = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    if (exp_adj >= 10'sd255) begin
      packed_res = {sign_q, 8'hFF, 23'd0};
    end else if (exp_adj <= 10'sd0) begin
      packed_res = {sign_q, 31'd0};
    end else begin
      packed_res = {sign_q, exp_adj[7:0], mant};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt     <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            b_q     <= i_b;
            o_ready <= 1'b0;
            state   <= PREP;
          end
        end
        PREP: begin
          if (special) begin
            o_res   <= special_res;
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            sign_q <= a_q[31] ^ b_q[31];
            exp_q  <= ea - eb + BIAS;
            mb_q   <= norm_b;
            rem_q  <= {1'b0, norm_a};
            quo_q  <= '0;
            cnt    <= '0;
            state  <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[23:0], quo_bit};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'(ITERS - 1)) state <= PACK;
        end
        PACK: begin
          o_res   <= packed_res;
          o_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floating_div_seq.sv
// Self-checking bench for floating_div_seq: directed vector table, stall and
// mid-division reset sequences, then random operands against a reference
// model built on plain integer division.
module tb_floating_div_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_a, i_b;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_res;
  logic        o_valid;
  logic        i_ready;

  int n_vec = 0;
  int n_bad = 0;

  floating_div_seq dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_res   (o_res),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  // Reference model: decode to integer significand and exponent, divide.
  function automatic void decode(input logic [31:0] x, output longint sig, output int e);
    if (x[30:23] == 8'h00) begin
      sig = longint'(x[22:0]);
      e   = 1;
      while (sig < 64'h80_0000) begin
        sig = sig * 2;
        e   = e - 1;
      end
    end else begin
      sig = longint'(x[22:0]) + 64'h80_0000;
      e   = int'(x[30:23]);
    end
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
    bit     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;
    longint sa, sb, q;
    int     ea, eb, e;
    logic [22:0] m;
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    s      = a[31] ^ b[31];
    special = 1'b1;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'hFFFF_FFFF;
    if (a_inf || b_zero) return {s, 8'hFF, 23'd0};
    if (b_inf || a_zero) return {s, 31'd0};
    special = 1'b0;
    decode(a, sa, ea);
    decode(b, sb, eb);
    q = (sa * 64'h100_0000) / sb;
    e = ea - eb + 127;
    if (q >= 64'h100_0000) begin
      m = 23'(q / 2);
    end else begin
      m = 23'(q);
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), m};
  endfunction

  // All tasks start and end #1 after a rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!o_ready && guard < 100) begin
      @(posedge i_clk); #1;
      guard++;
    end
    check("ready_before_accept", {31'd0, o_ready}, 32'd1);
    i_a = a;
    i_b = b;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1. Inputs are scrambled while
  // busy; the DUT must ignore them.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 60) begin
      i_a     = $urandom;
      i_b     = $urandom;
      i_valid = 1'($urandom);
      @(posedge i_clk); #1;
      lat++;
    end
    i_valid = 1'b0;
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int want_lat);
    int lat;
    start_op(a, b);
    wait_valid(lat);
    check({name, "_res"}, o_res, want);
    check({name, "_lat"}, 32'(lat), 32'(want_lat));
    consume();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x[30:0]  = 31'd0;
      1: x[30:23] = 8'h00;
      2: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
      3: x[30:23] = 8'hFF;
      default: x[30:23] = 8'($urandom_range(1, 254));
    endcase
    return x;
  endfunction

  vec_t vecs[$];

  initial begin
    int          lat;
    logic [31:0] a, b, want;
    bit          spc;

    vecs.push_back('{"six_div_two",   32'h40C00000, 32'h40000000, 32'h40400000, 28});
    vecs.push_back('{"one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28});
    vecs.push_back('{"x_div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 2});
    vecs.push_back('{"zero_div_zero", 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 2});
    vecs.push_back('{"ninf_div_x",    32'hFF800000, 32'h40000000, 32'hFF800000, 2});
    vecs.push_back('{"overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, 28});
    vecs.push_back('{"flush",         32'h00400000, 32'h3F800000, 32'h00000000, 28});
    vecs.push_back('{"sub_div_min",   32'h00400000, 32'h00800000, 32'h3F000000, 28});
    vecs.push_back('{"neg_six_two",   32'hC0C00000, 32'h40000000, 32'hC0400000, 28});
    vecs.push_back('{"nan_div_x",     32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 2});
    vecs.push_back('{"x_div_ninf",    32'h3F800000, 32'hFF800000, 32'h80000000, 2});
    vecs.push_back('{"nzero_div_x",   32'h80000000, 32'h3F800000, 32'h80000000, 2});
    vecs.push_back('{"inf_div_inf",   32'h7F800000, 32'h7F800000, 32'hFFFFFFFF, 2});

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_res",   o_res, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("idle_ready", {31'd0, o_ready}, 32'd1);
    check("idle_valid", {31'd0, o_valid}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // Back-pressure: hold i_ready low for 5 cycles in DONE.
    start_op(32'h40C00000, 32'h40000000);
    wait_valid(lat);
    check("stall_lat", 32'(lat), 32'd28);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_res_%0d", k),   o_res, 32'h40400000);
      check($sformatf("stall_valid_%0d", k), {31'd0, o_valid}, 32'd1);
      check($sformatf("stall_ready_%0d", k), {31'd0, o_ready}, 32'd0);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    #1;
    check("stall_ready_at_rise", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check("stall_ready_after", {31'd0, o_ready}, 32'd1);
    check("stall_valid_after", {31'd0, o_valid}, 32'd0);

    // Reset after the 10th DIV iteration: edge 1 enters DIV, edges 2..11 iterate.
    start_op(32'h3F800000, 32'h40400000);
    repeat (11) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_ready", {31'd0, o_ready}, 32'd1);
    check("midrst_res",   o_res, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("postrst_valid", {31'd0, o_valid}, 32'd0);
    run_vec("post_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 28);

    for (int n = 0; n < 60; n++) begin
      a    = rand_operand();
      b    = rand_operand();
      want = ref_div(a, b, spc);
      run_vec($sformatf("rand%0d_%08h_%08h", n, a, b), a, b, want, spc ? 2 : 28);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/floating_div_seq.md
FLOATING_DIV_SEQ -- requirements
Module: floating_div_seq

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port i_a, input, 32 bits: IEEE-754 single-precision dividend.
REQ-004 SHALL have port i_b, input, 32 bits: IEEE-754 single-precision divisor.
REQ-005 SHALL have port i_valid, input, 1 bit: operands valid.
REQ-006 SHALL have port o_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port o_res, output, 32 bits: quotient a/b.
REQ-008 SHALL have port o_valid, output, 1 bit: o_res valid.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream consumes o_res.

Function
REQ-010 SHALL accept operands on a rising edge where i_valid and o_ready are both high, and SHALL register i_a and i_b internally on that edge.
REQ-011 SHALL drive o_ready high only in state IDLE.
REQ-012 SHALL implement states IDLE, PREP, DIV, PACK, DONE.
REQ-013 Transitions SHALL be:
- IDLE->PREP on accept.
- PREP->DIV for normal/subnormal operand pairs; PREP->DONE for special cases.
- DIV->PACK after exactly 25 iterations.
- PACK->DONE.
- DONE->IDLE on the edge where i_ready is high.
REQ-014 Classification SHALL use these 3-bit codes:
- zero 000: E=0, M=0.
- subnormal 001: E=0, M!=0.
- normal 011: everything else.
- inf 100: E=FF, M=0.
- NaN 110: E=FF, M!=0.
REQ-015 Special-case results SHALL be, in priority order:
- Any NaN, 0/0, or inf/inf -> 0xFFFFFFFF.
- inf/x -> signed inf.
- x/0 -> signed inf.
- x/inf -> signed zero.
- 0/x -> signed zero.
REQ-016 Result sign SHALL be Sa XOR Sb, except for the NaN result.
REQ-017 In PREP, a subnormal significand SHALL be normalized by left-shifting it by its leading-zero count z (24-bit significand with hidden bit 0); its effective exponent SHALL be 1-z.
REQ-018 Normal significands SHALL be {1, M}, 24 bits, with exponent E.
REQ-019 DIV SHALL perform restoring division, one quotient bit per cycle, MSB first, producing 25-bit q = floor((Ma<<24)/Mb).
REQ-020 The exponent SHALL be computed as a 10-bit signed value Ea-Eb+127.
REQ-021 If q[24]=1, the mantissa SHALL be q[23:1]; otherwise the mantissa SHALL be q[22:0] and the exponent SHALL be decremented by 1.
REQ-022 Rounding SHALL be truncation.
REQ-023 In PACK, exponent >= 255 SHALL give signed inf, and exponent <= 0 SHALL give signed zero (flush, no subnormal output).
REQ-024 Latency from the accept edge to o_valid high SHALL be 28 cycles for the normal path and 2 cycles for the special-case path.
REQ-025 In DONE, o_valid SHALL be high and o_res SHALL be held stable until i_ready is high; o_valid SHALL drop on the edge after that.
REQ-026 Changes on i_a, i_b or i_valid outside IDLE SHALL be ignored.

Reset
REQ-027 On i_rst_n low, the block SHALL enter IDLE immediately, in any state including mid-DIV, and SHALL abandon any in-flight operation.
REQ-028 Reset values SHALL be: o_valid=0, o_ready=1 (after the state settles to IDLE), o_res=0x00000000, iteration counter=0.

Structure
REQ-029 A shared package fp_div_pkg SHALL hold:
- The class codes.
- The state encoding.
- The NaN constant 0xFFFFFFFF.
- The bias 127.
- The iteration count 25.
REQ-030 Subnormal normalization SHALL instantiate the team's existing zero_counter module (24-bit in, 5-bit count).
REQ-031 The datapath and FSM SHALL otherwise live in floating_div_seq.

Verification
REQ-032 Bench SHALL apply 0x40C00000 / 0x40000000 -> o_res 0x40400000, with o_valid 28 cycles after accept.
REQ-033 Bench SHALL apply 0x3F800000 / 0x40400000 -> o_res 0x3EAAAAAA (truncated).
REQ-034 Bench SHALL apply the special-case vectors below, each with o_valid 2 cycles after accept:
- 0x3F800000 / 0x00000000 -> 0x7F800000.
- 0x00000000 / 0x00000000 -> 0xFFFFFFFF.
- 0xFF800000 / 0x40000000 -> 0xFF800000.
REQ-035 Bench SHALL apply 0x7F000000 / 0x3E800000 -> o_res 0x7F800000 (overflow), and 0x00400000 / 0x3F800000 -> o_res 0x00000000 (flush).
REQ-036 Bench SHALL hold i_ready low for 5 cycles in DONE -> o_res stable and o_valid high throughout, and o_ready low until one cycle after i_ready rises.
REQ-037 Bench SHALL assert i_rst_n low at DIV iteration 10 -> o_valid=0 and o_ready=1 immediately; the next operation 0x40C00000 / 0x40000000 SHALL return 0x40400000.
